// File: rtl/mac_share_arbiter.sv
// rtl/mac_share_arbiter.sv - round-robin arbiter and sequencer for the shared multiply/add unit
// Registered outputs; one requester owns the unit from grant until its done pulse.
module mac_share_arbiter #(
  parameter int NUM_REQ   = 3,
  parameter int LOOPS_MUL = 10,
  parameter int LOOPS_ADD = 10,
  parameter int CNT_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] op_sel,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         src_sel,
  output logic               mul_en,
  output logic               add_en,
  output logic [NUM_REQ-1:0] done,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MUL_LAST  = CNT_WIDTH'(LOOPS_MUL - 1);
  localparam logic [CNT_WIDTH-1:0] ADD_LAST  = CNT_WIDTH'(LOOPS_ADD - 1);
  localparam logic [1:0]           LAST_INIT = 2'(NUM_REQ - 1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic [1:0]           last_grant, last_grant_nxt;
  logic [1:0]           src_sel_nxt;
  logic [NUM_REQ-1:0]   grant_nxt;
  logic [NUM_REQ-1:0]   done_nxt;
  logic                 mul_en_nxt;
  logic                 add_en_nxt;

  // Pad to four lanes so a 2-bit index is legal for any NUM_REQ in range.
  logic [3:0] req_pad;
  logic [3:0] op_pad;
  always_comb begin
    req_pad                = '0;
    op_pad                 = '0;
    req_pad[NUM_REQ-1:0]   = req;
    op_pad[NUM_REQ-1:0]    = op_sel;
  end

  logic       win_found;
  logic [1:0] winner;
  logic [3:0] win_onehot;
  int         idx_int;

  always_comb begin
    win_found = 1'b0;
    winner    = 2'd0;
    idx_int   = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx_int = (int'(last_grant) + i) % NUM_REQ;
      if (!win_found && req_pad[idx_int[1:0]]) begin
        win_found = 1'b1;
        winner    = idx_int[1:0];
      end
    end
  end

  assign win_onehot = 4'b0001 << winner;

  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    src_sel_nxt    = src_sel;
    grant_nxt      = grant;
    done_nxt       = '0;
    mul_en_nxt     = 1'b0;
    add_en_nxt     = 1'b0;
    case (state)
      IDLE: begin
        grant_nxt = '0;
        if (win_found) begin
          src_sel_nxt = winner;
          grant_nxt   = win_onehot[NUM_REQ-1:0];
          cnt_nxt     = '0;
          if (op_pad[winner]) begin
            state_nxt  = ADD;
            add_en_nxt = 1'b1;
          end else begin
            state_nxt  = MUL;
            mul_en_nxt = 1'b1;
          end
        end
      end
      MUL: begin
        cnt_nxt = cnt + CNT_WIDTH'(1);
        if (cnt == MUL_LAST) begin
          state_nxt = DONE;
          done_nxt  = grant;
        end else begin
          mul_en_nxt = 1'b1;
        end
      end
      ADD: begin
        cnt_nxt = cnt + CNT_WIDTH'(1);
        if (cnt == ADD_LAST) begin
          state_nxt = DONE;
          done_nxt  = grant;
        end else begin
          add_en_nxt = 1'b1;
        end
      end
      DONE: begin
        last_grant_nxt = src_sel;
        grant_nxt      = '0;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= LAST_INIT;
      src_sel    <= 2'd0;
      grant      <= '0;
      done       <= '0;
      mul_en     <= 1'b0;
      add_en     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      src_sel    <= src_sel_nxt;
      grant      <= grant_nxt;
      done       <= done_nxt;
      mul_en     <= mul_en_nxt;
      add_en     <= add_en_nxt;
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mac_share_arbiter.sv
// tb/tb_mac_share_arbiter.sv - table-driven bench for mac_share_arbiter
// Each record: inputs driven for one cycle plus the outputs expected during that cycle.
module tb_mac_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] req = 3'b000;
  logic [2:0] op_sel = 3'b000;
  logic [2:0] grant;
  logic [1:0] src_sel;
  logic       mul_en;
  logic       add_en;
  logic [2:0] done;
  logic       busy;

  always #5 clk = ~clk;

  mac_share_arbiter #(
    .NUM_REQ(3), .LOOPS_MUL(10), .LOOPS_ADD(10), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .op_sel(op_sel),
    .grant(grant), .src_sel(src_sel), .mul_en(mul_en), .add_en(add_en),
    .done(done), .busy(busy)
  );

  typedef struct {
    logic       rst_n;
    logic [2:0] req;
    logic [2:0] op;
    logic [2:0] grant;
    logic       mul;
    logic       add;
    logic [2:0] done;
    logic       busy;
    logic [1:0] src;
    logic       chk;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add_run(input int n, input logic r, input logic [2:0] rq, input logic [2:0] op,
                         input logic [2:0] g, input logic m, input logic a, input logic [2:0] d,
                         input logic b, input logic [1:0] s, input logic c);
    vec_t v;
    v.rst_n = r; v.req = rq; v.op = op; v.grant = g; v.mul = m; v.add = a;
    v.done = d; v.busy = b; v.src = s; v.chk = c;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic idle(input int n, input logic [2:0] rq, input logic [2:0] op);
    add_run(n, 1'b1, rq, op, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b1);
  endtask

  task automatic do_reset(input int n);
    add_run(n, 1'b0, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  initial begin
    // reset state, then idle
    do_reset(2);
    idle(5, 3'b000, 3'b000);

    // single multiply from requester 0
    idle(1, 3'b001, 3'b000);
    add_run(10, 1, 3'b001, 3'b000, 3'b001, 1, 0, 3'b000, 1, 2'd0, 1);
    add_run(1,  1, 3'b001, 3'b000, 3'b001, 0, 0, 3'b001, 1, 2'd0, 1);
    idle(2, 3'b000, 3'b000);

    // all three request continuously: order 0,1,2,0; requester 1 adds
    do_reset(1);
    idle(1, 3'b111, 3'b010);
    add_run(10, 1, 3'b111, 3'b010, 3'b001, 1, 0, 3'b000, 1, 2'd0, 1);
    add_run(1,  1, 3'b111, 3'b010, 3'b001, 0, 0, 3'b001, 1, 2'd0, 1);
    idle(1, 3'b111, 3'b010);
    add_run(10, 1, 3'b111, 3'b010, 3'b010, 0, 1, 3'b000, 1, 2'd1, 1);
    add_run(1,  1, 3'b111, 3'b010, 3'b010, 0, 0, 3'b010, 1, 2'd1, 1);
    idle(1, 3'b111, 3'b010);
    add_run(10, 1, 3'b111, 3'b010, 3'b100, 1, 0, 3'b000, 1, 2'd2, 1);
    add_run(1,  1, 3'b111, 3'b010, 3'b100, 0, 0, 3'b100, 1, 2'd2, 1);
    idle(1, 3'b111, 3'b010);
    add_run(10, 1, 3'b111, 3'b010, 3'b001, 1, 0, 3'b000, 1, 2'd0, 1);
    add_run(1,  1, 3'b111, 3'b010, 3'b001, 0, 0, 3'b001, 1, 2'd0, 1);
    idle(2, 3'b000, 3'b000);

    // requester 2 drops req and flips op_sel mid-operation: still a full multiply
    do_reset(1);
    idle(1, 3'b100, 3'b000);
    add_run(2, 1, 3'b100, 3'b000, 3'b100, 1, 0, 3'b000, 1, 2'd2, 1);
    add_run(8, 1, 3'b000, 3'b100, 3'b100, 1, 0, 3'b000, 1, 2'd2, 1);
    add_run(1, 1, 3'b000, 3'b100, 3'b100, 0, 0, 3'b100, 1, 2'd2, 1);
    idle(2, 3'b000, 3'b000);

    // reset in cycle 5 of a multiply aborts it; requester 1 then wins over 2
    do_reset(1);
    idle(1, 3'b001, 3'b000);
    add_run(4, 1, 3'b001, 3'b000, 3'b001, 1, 0, 3'b000, 1, 2'd0, 1);
    add_run(1, 0, 3'b001, 3'b000, 3'b001, 1, 0, 3'b000, 1, 2'd0, 1);
    idle(1, 3'b110, 3'b000);
    add_run(10, 1, 3'b110, 3'b000, 3'b010, 1, 0, 3'b000, 1, 2'd1, 1);
    add_run(1,  1, 3'b110, 3'b000, 3'b010, 0, 0, 3'b010, 1, 2'd1, 1);
    idle(2, 3'b000, 3'b000);

    for (int k = 0; k < vq.size(); k++) begin
      @(negedge clk);
      if (vq[k].chk) begin
        check("grant",  k, 8'(grant),  8'(vq[k].grant));
        check("mul_en", k, 8'(mul_en), 8'(vq[k].mul));
        check("add_en", k, 8'(add_en), 8'(vq[k].add));
        check("done",   k, 8'(done),   8'(vq[k].done));
        check("busy",   k, 8'(busy),   8'(vq[k].busy));
        if (vq[k].busy) check("src_sel", k, 8'(src_sel), 8'(vq[k].src));
      end
      check("grant_onehot0", k, 8'($onehot0(grant)), 8'd1);
      check("enables_excl",  k, 8'(mul_en & add_en), 8'd0);
      if (done != 3'b000) begin
        check("done_vs_grant", k, 8'(done), 8'(grant));
        check("done_no_en",    k, 8'(mul_en | add_en), 8'd0);
        check("done_busy",     k, 8'(busy), 8'd1);
      end
      rst_n  = vq[k].rst_n;
      req    = vq[k].req;
      op_sel = vq[k].op;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_share_arbiter.md
Name: mac_share_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared multicycle multiplier/adder in the feature pipeline.
- Requesters are the cepstrum controller, the filterbank controller and the log stage.
- Grants the unit to one requester at a time and drives the operand mux select.
- Times each multiply or add with an internal loop counter and returns a one-cycle completion pulse to the winner.

Parameters:
- NUM_REQ, 3, number of requesters; legal range 2..4.
- LOOPS_MUL, 10, cycles mul_en is held per multiply; legal range 1..15.
- LOOPS_ADD, 10, cycles add_en is held per add; legal range 1..15.
- CNT_WIDTH, 4, loop counter width; each LOOPS value must be < 2^CNT_WIDTH.

Ports:
- clk  input  1  system clock, all logic on its rising edge.
- rst_n  input  1  synchronous active-low reset.
- req  input  NUM_REQ  request per requester; level, held until done.
- op_sel  input  NUM_REQ  per-requester operation: 0 = multiply, 1 = add; sampled only at grant.
- grant  output  NUM_REQ  one-hot, high for the whole operation of the winner.
- src_sel  output  2  binary index of the granted requester; drives the operand/result mux.
- mul_en  output  1  multiplier enable.
- add_en  output  1  adder enable.
- done  output  NUM_REQ  one-cycle pulse to the winner when its result is valid.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low at a rising edge):
  - state goes to IDLE; counter is 0.
  - grant, done, mul_en, add_en, busy and src_sel are all 0.
  - last_grant goes to NUM_REQ-1, so requester 0 has top priority first.
  - Reset mid-operation aborts the operation with no done pulse.
- States: IDLE, MUL, ADD, DONE. Outputs are registered, so they change only at a clock edge.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - On the next edge: latch winner into src_sel and grant, latch op_sel[winner], counter goes to 0.
  - Next state is MUL if op_sel[winner] = 0, else ADD.
  - If no req bit is set, stay in IDLE.
- MUL:
  - mul_en = 1, add_en = 0.
  - Counter increments each cycle.
  - When counter = LOOPS_MUL-1, the next state is DONE.
  - mul_en is high for exactly LOOPS_MUL cycles.
- ADD: same as MUL, with add_en and LOOPS_ADD.
- DONE:
  - mul_en = add_en = 0; grant stays high; done[src_sel] = 1 for this single cycle.
  - last_grant is set to src_sel; next state is IDLE.
  - grant clears on entry to IDLE.
- Latency: req sampled at edge 0 → grant/enable from cycle 1 → done in cycle LOOPS+1 → IDLE in cycle LOOPS+2.
  - Back-to-back operations therefore take LOOPS+2 cycles each.
- Requester rules:
  - A requester must drop req in the cycle after its done, or it is arbitrated again.
  - Round-robin order still gives every other pending requester priority first.
- req deasserted mid-operation: ignored; the operation runs to completion and done still pulses.
- op_sel changes after grant: ignored.
- Simultaneous requests: resolved strictly by round-robin; no starvation.
  - Worst-case wait is (NUM_REQ-1)×(max LOOPS+2) cycles.
- Requester indices ≥ NUM_REQ do not exist; the unused upper src_sel bit is 0 when NUM_REQ ≤ 2.
- mul_en and add_en are never high together.
- grant is always either zero or one-hot.

Test Plan:
- Reset, then idle 5 cycles with req = 000 → all outputs 0, busy 0.
- req = 001, op_sel = 000 → grant = 001 from cycle 1, mul_en high cycles 1-10, done[0] in cycle 11, busy low in cycle 12.
- req = 111 held continuously, op_sel = 010 → grant order 001, 010, 100, 001.
  - Requester 1's add_en window is 10 cycles; each operation spans 12 cycles.
- req = 100 dropped in cycle 3 of its operation → operation completes and done[2] still pulses in cycle 11.
- rst_n low in cycle 5 of a multiply → all outputs 0 on the next edge, no done.
  - After release, req = 110 is granted to requester 1 first.
- Assertion checks on every cycle:
  - grant is one-hot or zero.
  - mul_en and add_en are never both high.
  - done only ever coincides with the DONE state and matches grant.
